// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared prediction metadata type, constants and saturating increment.
package branch_resolve_unit_pkg;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam int CNT_W = 32;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } pred_meta_t;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + CNT_W'(1) : v;
    endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: fetch/execute inputs and BHT/redirect/statistics outputs of the resolve unit.
interface branch_resolve_unit_if #(parameter int BHT_ADDR_LEN = 7);
    logic                    stall;
    logic [31:0]             if_pc;
    logic                    if_pred_taken;
    logic [31:0]             if_pred_target;
    logic                    ex_is_br;
    logic                    ex_br_taken;
    logic [31:0]             ex_br_target;
    logic                    bht_we;
    logic [BHT_ADDR_LEN-1:0] bht_waddr;
    logic                    bht_taken;
    logic                    flush;
    logic [31:0]             redirect_pc;
    logic [31:0]             br_cnt;
    logic [31:0]             miss_cnt;
    modport master (
        output stall, if_pc, if_pred_taken, if_pred_target, ex_is_br, ex_br_taken, ex_br_target,
        input  bht_we, bht_waddr, bht_taken, flush, redirect_pc, br_cnt, miss_cnt
    );
    modport slave (
        input  stall, if_pc, if_pred_taken, if_pred_target, ex_is_br, ex_br_taken, ex_br_target,
        output bht_we, bht_waddr, bht_taken, flush, redirect_pc, br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_resolve_unit_pred_meta_stage.sv
// pred_meta_stage: one pipeline register of prediction metadata; holds on stall, bubbles on flush.
module pred_meta_stage
    import branch_resolve_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_stall,
    input  logic       i_flush,
    input  pred_meta_t i_d,
    output pred_meta_t o_q
);
    pred_meta_t r_q;
    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (!i_stall)
            r_q <= i_flush ? '0 : i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries predictions to EX, detects mispredicts, drives BHT update, flush, redirect and stats.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int BHT_ADDR_LEN = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave io_bus
);
    pred_meta_t       w_if_meta;
    pred_meta_t       w_id;
    pred_meta_t       w_m;
    logic             w_go;
    logic             w_br_miss;
    logic             w_alias_miss;
    logic             w_flush;
    logic             w_bht_we;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    assign w_if_meta = '{valid: 1'b1, pc: io_bus.if_pc, pred_taken: io_bus.if_pred_taken,
                         pred_target: io_bus.if_pred_target};

    pred_meta_stage u_if_id (
        .clk(clk), .rst(rst), .i_stall(io_bus.stall), .i_flush(w_flush), .i_d(w_if_meta), .o_q(w_id)
    );
    pred_meta_stage u_id_ex (
        .clk(clk), .rst(rst), .i_stall(io_bus.stall), .i_flush(w_flush), .i_d(w_id), .o_q(w_m)
    );

    assign w_go         = w_m.valid & ~io_bus.stall;
    assign w_br_miss    = w_go & io_bus.ex_is_br & ((w_m.pred_taken != io_bus.ex_br_taken) |
                          (io_bus.ex_br_taken & (w_m.pred_target != io_bus.ex_br_target)));
    assign w_alias_miss = w_go & ~io_bus.ex_is_br & w_m.pred_taken;
    assign w_flush      = w_br_miss | w_alias_miss;
    assign w_bht_we     = w_go & io_bus.ex_is_br;

    assign io_bus.flush       = w_flush;
    assign io_bus.redirect_pc = (io_bus.ex_br_taken & io_bus.ex_is_br) ? io_bus.ex_br_target : w_m.pc + PC_INC;
    assign io_bus.bht_we      = w_bht_we;
    assign io_bus.bht_waddr   = w_m.pc[BHT_ADDR_LEN+1:2];
    assign io_bus.bht_taken   = io_bus.ex_br_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_br_cnt   <= sat_inc(r_br_cnt, w_bht_we);
            r_miss_cnt <= sat_inc(r_miss_cnt, w_flush);
        end
    end

    assign io_bus.br_cnt   = r_br_cnt;
    assign io_bus.miss_cnt = r_miss_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors for the branch resolve unit with hand-computed expectations.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    branch_resolve_unit_if #(.BHT_ADDR_LEN(7)) bus ();
    branch_resolve_unit #(.BHT_ADDR_LEN(7)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                       input logic br, input logic tk, input logic [31:0] tgt);
        bus.if_pc          = pc;
        bus.if_pred_taken  = pt;
        bus.if_pred_target = ptgt;
        bus.ex_is_br       = br;
        bus.ex_br_taken    = tk;
        bus.ex_br_target   = tgt;
        #1;
    endtask

    initial begin
        bus.stall = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_flush", 32'(bus.flush), 0);
        chk("rst_we", 32'(bus.bht_we), 0);
        chk("rst_br_cnt", bus.br_cnt, 0);
        chk("rst_miss_cnt", bus.miss_cnt, 0);
        // correct not-taken branch at 0x100
        drv(32'h100, 0, 0, 0, 0, 0); tick();
        drv(32'h104, 0, 0, 0, 0, 0); tick();
        drv(32'h200, 0, 0, 1, 0, 0);
        chk("nt_we", 32'(bus.bht_we), 1);
        chk("nt_waddr", 32'(bus.bht_waddr), 32'h40);
        chk("nt_taken", 32'(bus.bht_taken), 0);
        chk("nt_flush", 32'(bus.flush), 0);
        tick();
        chk("nt_br_cnt", bus.br_cnt, 1);
        chk("nt_miss_cnt", bus.miss_cnt, 0);
        // direction miss at 0x200, actually taken to 0x280
        drv(32'h204, 0, 0, 0, 0, 0); tick();
        drv(32'h208, 0, 0, 1, 1, 32'h280);
        chk("dir_flush", 32'(bus.flush), 1);
        chk("dir_redirect", bus.redirect_pc, 32'h280);
        chk("dir_taken", 32'(bus.bht_taken), 1);
        chk("dir_waddr", 32'(bus.bht_waddr), 32'h00);
        tick();
        chk("dir_miss_cnt", bus.miss_cnt, 1);
        chk("dir_br_cnt", bus.br_cnt, 2);
        drv(32'h280, 0, 0, 1, 1, 32'h999);
        chk("killed1_we", 32'(bus.bht_we), 0);
        chk("killed1_flush", 32'(bus.flush), 0);
        tick();
        drv(32'h284, 0, 0, 1, 1, 32'h999);
        chk("killed2_we", 32'(bus.bht_we), 0);
        chk("killed2_flush", 32'(bus.flush), 0);
        tick();
        chk("killed_br_cnt", bus.br_cnt, 2);
        chk("killed_miss_cnt", bus.miss_cnt, 1);
        // target miss: predicted 0x300, actual 0x340
        drv(32'h2F0, 1, 32'h300, 0, 0, 0); tick();
        drv(32'h300, 0, 0, 0, 0, 0); tick();
        drv(32'h304, 0, 0, 1, 1, 32'h340);
        chk("tgt_flush", 32'(bus.flush), 1);
        chk("tgt_redirect", bus.redirect_pc, 32'h340);
        chk("tgt_waddr", 32'(bus.bht_waddr), 32'h3C);
        tick();
        chk("tgt_miss_cnt", bus.miss_cnt, 2);
        chk("tgt_br_cnt", bus.br_cnt, 3);
        // alias: non-branch at 0x400 fetched as taken
        drv(32'h400, 1, 32'h500, 0, 0, 0); tick();
        drv(32'h500, 0, 0, 0, 0, 0); tick();
        drv(32'h504, 0, 0, 0, 0, 0);
        chk("alias_flush", 32'(bus.flush), 1);
        chk("alias_redirect", bus.redirect_pc, 32'h404);
        chk("alias_we", 32'(bus.bht_we), 0);
        tick();
        chk("alias_br_cnt", bus.br_cnt, 3);
        chk("alias_miss_cnt", bus.miss_cnt, 3);
        // stalled mispredict: predicted taken, actually not taken
        drv(32'h600, 1, 32'h700, 0, 0, 0); tick();
        drv(32'h700, 0, 0, 0, 0, 0); tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(32'h704, 0, 0, 1, 0, 0);
            chk("stall_flush", 32'(bus.flush), 0);
            chk("stall_we", 32'(bus.bht_we), 0);
            tick();
        end
        chk("stall_miss_cnt", bus.miss_cnt, 3);
        chk("stall_br_cnt", bus.br_cnt, 3);
        bus.stall = 1'b0;
        drv(32'h704, 0, 0, 1, 0, 0);
        chk("unstall_flush", 32'(bus.flush), 1);
        chk("unstall_redirect", bus.redirect_pc, 32'h604);
        chk("unstall_we", 32'(bus.bht_we), 1);
        tick();
        chk("unstall_miss_cnt", bus.miss_cnt, 4);
        chk("unstall_br_cnt", bus.br_cnt, 4);
        drv(32'h608, 0, 0, 1, 1, 32'h123);
        chk("post_stall_flush", 32'(bus.flush), 0);
        tick();
        // miss counter saturation
        force dut.r_miss_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_miss_cnt;
        chk("sat_preset", bus.miss_cnt, 32'hFFFF_FFFE);
        for (int i = 0; i < 2; i++) begin
            drv(32'h800, 1, 32'h900, 0, 0, 0); tick();
            drv(32'h900, 0, 0, 0, 0, 0); tick();
            drv(32'h904, 0, 0, 0, 0, 0);
            chk("sat_flush", 32'(bus.flush), 1);
            tick();
            chk("sat_miss_cnt", bus.miss_cnt, 32'hFFFF_FFFF);
        end
        // reset with valid entries in both stages
        drv(32'hA00, 0, 0, 0, 0, 0); tick();
        drv(32'hA04, 1, 32'hB00, 0, 0, 0); tick();
        rst = 1'b1;
        drv(32'hA08, 0, 0, 0, 0, 0); tick();
        rst = 1'b0;
        drv(32'hA0C, 0, 0, 1, 1, 32'h777);
        chk("mrst_flush", 32'(bus.flush), 0);
        chk("mrst_we", 32'(bus.bht_we), 0);
        chk("mrst_br_cnt", bus.br_cnt, 0);
        chk("mrst_miss_cnt", bus.miss_cnt, 0);
        tick();
        drv(32'hA10, 0, 0, 0, 0, 0);
        chk("mrst_id_flush", 32'(bus.flush), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
